// File: rtl/redcim_bf16_accum_if.sv
// Stream bundle for the BF16 group accumulator: element input and group-sum output.
interface redcim_bf16_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/redcim_bf16_accum.sv
// BF16 group accumulator: one element per 4 cycles (WAIT/ALIGN/ADD/NORM), sum emitted on in_last.
// Define REDCIM_ACC_SAT_EN to saturate on exponent overflow instead of producing infinity.
module redcim_bf16_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  redcim_bf16_accum_if.slave bus,
  output logic [CNT_W-1:0] acc_count
);

  typedef enum logic [2:0] {WAIT, ALIGN, ADD, NORM, OUT} state_t;
  state_t state, state_nx;

  logic        in_ready, out_valid, xfer;
  logic [15:0] acc_q, op_q, out_q;
  logic        last_q, inf_q;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      WAIT: begin
        in_ready = !rst;
        if (bus.in_valid && !rst) state_nx = ALIGN;
      end
      ALIGN: state_nx = ADD;
      ADD:   state_nx = NORM;
      NORM:  state_nx = last_q ? OUT : WAIT;
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = WAIT;
      end
      default: state_nx = WAIT;
    endcase
  end

  assign xfer          = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_q;

  // ALIGN: hidden one + 7 mantissa + 3 guard bits; zero-exponent operands contribute nothing
  logic [7:0]  ea, eb, big_e, diff;
  logic [10:0] ma_c, mb_c, mx, my;
  logic        sx, sy;
  always_comb begin
    ea   = acc_q[14:7];
    eb   = op_q[14:7];
    ma_c = (ea == 8'd0) ? 11'd0 : {1'b1, acc_q[6:0], 3'b000};
    mb_c = (eb == 8'd0) ? 11'd0 : {1'b1, op_q[6:0], 3'b000};
    if (ea >= eb) begin
      big_e = ea; diff = ea - eb; mx = ma_c; sx = acc_q[15]; my = mb_c; sy = op_q[15];
    end else begin
      big_e = eb; diff = eb - ea; mx = mb_c; sx = op_q[15]; my = ma_c; sy = acc_q[15];
    end
    if (diff >= 8'd11) my = 11'd0;
    else               my = my >> diff;
  end

  logic [7:0]  al_e;
  logic [10:0] al_x, al_y;
  logic        al_sx, al_sy;

  // ADD: sign-magnitude; exact cancellation yields +0
  logic [11:0] sum_c;
  logic        sgn_c;
  always_comb begin
    if (al_sx == al_sy) begin
      sum_c = {1'b0, al_x} + {1'b0, al_y}; sgn_c = al_sx;
    end else if (al_x >= al_y) begin
      sum_c = {1'b0, al_x - al_y}; sgn_c = al_sx;
    end else begin
      sum_c = {1'b0, al_y - al_x}; sgn_c = al_sy;
    end
    if (sum_c == 12'd0) sgn_c = 1'b0;
  end

  logic [11:0] sum_q;
  logic        sgn_q;
  logic [7:0]  exp_q;

  // NORM: carry shifts right, otherwise leading-one shift left; truncate
  logic [3:0]        lz;
  logic              found;
  logic signed [9:0] n_exp;
  logic [6:0]        n_mant;
  logic [15:0]       res;
  logic              ovf;
  always_comb begin
    lz    = 4'd0;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        lz    = 4'(10 - i);
        found = 1'b1;
      end
    end
    if (sum_q[11]) begin
      n_exp  = $signed({2'b00, exp_q}) + 10'sd1;
      n_mant = sum_q[10:4];
    end else begin
      n_exp  = $signed({2'b00, exp_q}) - $signed({6'd0, lz});
      n_mant = 7'((sum_q[10:0] << lz) >> 3);
    end
    ovf = 1'b0;
    res = {sgn_q, n_exp[7:0], n_mant};
    if (sum_q == 12'd0 || n_exp <= 10'sd0) begin
      res = 16'h0000;
    end else if (n_exp >= 10'sd255) begin
      ovf = 1'b1;
`ifdef REDCIM_ACC_SAT_EN
      res = {sgn_q, 15'h7F7F};
`else
      res = {sgn_q, 15'h7F80};
`endif
    end
    if (inf_q) res = acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0; op_q <= '0; out_q <= '0; last_q <= 1'b0; inf_q <= 1'b0;
      acc_count <= '0;
      al_e <= '0; al_x <= '0; al_y <= '0; al_sx <= 1'b0; al_sy <= 1'b0;
      sum_q <= '0; sgn_q <= 1'b0; exp_q <= '0;
    end else begin
      al_e <= big_e; al_x <= mx; al_y <= my; al_sx <= sx; al_sy <= sy;
      sum_q <= sum_c; sgn_q <= sgn_c; exp_q <= al_e;
      case (state)
        WAIT: if (xfer) begin
          op_q   <= bus.in_data;
          last_q <= bus.in_last;
          if (acc_count != '1) acc_count <= acc_count + CNT_W'(1);
        end
        NORM: begin
          acc_q <= res;
`ifdef REDCIM_ACC_SAT_EN
          inf_q <= 1'b0;
`else
          inf_q <= inf_q | ovf;
`endif
          if (last_q) out_q <= res;
        end
        OUT: if (bus.out_ready) begin
          acc_q <= '0; inf_q <= 1'b0; acc_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_redcim_bf16_accum.sv
// Directed bench for redcim_bf16_accum: expected group sums queued at stimulus time, checked at output.
module tb_redcim_bf16_accum;
  localparam int CNT_W = 8;

`ifdef REDCIM_ACC_SAT_EN
  localparam logic [15:0] OVF_POS = 16'h7F7F;
`else
  localparam logic [15:0] OVF_POS = 16'h7F80;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] acc_count;
  always #5 clk = ~clk;

  redcim_bf16_accum_if bus();
  redcim_bf16_accum #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus), .acc_count(acc_count));

  typedef struct packed {
    logic [15:0]      data;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_grp(input logic [15:0] d, input logic [CNT_W-1:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input bit chk_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 200);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_data"}, 32'(bus.out_data), 32'(e.data));
      chk({tag, "_count"}, 32'(acc_count), 32'(e.cnt));
    end
    if (chk_lat) chk({tag, "_latency"}, 32'(n), 32'd4);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_count"}, 32'(acc_count), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] held;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_count", 32'(acc_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 1.0 + 1.0 with output latency
    expect_grp(16'h4000, 8'd2);
    send(16'h3F80, 1'b0);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    send(16'h3F80, 1'b1);
    recv("one_plus_one", 1'b1);

    expect_grp(16'h0000, 8'd1 + 8'd1);
    send(16'h3F80, 1'b0);
    send(16'hBF80, 1'b1);
    recv("cancel", 1'b0);

    expect_grp(16'h4060, 8'd3);
    send(16'h4000, 1'b0);
    send(16'h3F80, 1'b0);
    send(16'h3F00, 1'b1);
    recv("three_half", 1'b0);

    expect_grp(16'h4B80, 8'd2);
    send(16'h4B80, 1'b0);
    send(16'h3F80, 1'b1);
    recv("aligned_out", 1'b0);

    expect_grp(16'h3F81, 8'd2);
    send(16'h3F80, 1'b0);
    send(16'h3C00, 1'b1);
    recv("shift7", 1'b0);

    expect_grp(16'hBF80, 8'd2);
    send(16'hC000, 1'b0);
    send(16'h3F80, 1'b1);
    recv("neg_result", 1'b0);

    expect_grp(16'h0000, 8'd1);
    send(16'h0001, 1'b1);
    recv("denorm_single", 1'b0);

    expect_grp(16'h0000, 8'd1);
    send(16'h8000, 1'b1);
    recv("negzero_single", 1'b0);

    expect_grp(16'h0000, 8'd2);
    send(16'h00C0, 1'b0);
    send(16'h8080, 1'b1);
    recv("underflow", 1'b0);

    expect_grp(OVF_POS, 8'd2);
    send(16'h7F7F, 1'b0);
    send(16'h7F7F, 1'b1);
    recv("overflow", 1'b0);

    expect_grp(OVF_POS, 8'd3);
    send(16'h7F7F, 1'b0);
    send(16'h7F7F, 1'b0);
    send(16'hBF80, 1'b1);
    recv("overflow_continue", 1'b0);

    // counter saturation
    expect_grp(16'h0000, '1);
    for (int i = 0; i < 300; i++) send(16'h0000, i == 299);
    recv("count_sat", 1'b0);

    // output back-pressure
    expect_grp(16'h3F80, 8'd1);
    send(16'h3F80, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 200);
    held = bus.out_data;
    chk("stall_first", 32'(held), 32'h3F80);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'h3F80);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    recv("stall", 1'b0);

    // reset while in ADD abandons the group
    send(16'h4000, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_count", 32'(acc_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_rel_ready", 32'(bus.in_ready), 32'd1);
    expect_grp(16'h3F80, 8'd1);
    send(16'h3F80, 1'b1);
    recv("after_rst", 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
